pll_reset_supervisor: RTL

- Parametrised lock supervisor and reset sequencer that sits beside an ECP5 EHXPLLL clock generator, in the reference-clock domain (e.g. 25 MHz clkin).
- Synchronises and qualifies the PLL lock, and pulses the PLL reset when lock does not arrive within a timeout.
- Releases per-output-clock reset requests in a staggered order and counts lock-loss events.
- Successor to the fixed-configuration clock wrappers. The channel count and all timings are generics, and it adds retry and lost-lock recovery.

---
 rtl/pll_reset_supervisor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_supervisor.sv
// Lock supervisor and reset sequencer for an ECP5 EHXPLLL, running in the reference-clock domain.
// Qualifies PLL lock, retries the PLL on timeout and releases per-channel resets in staggered order.
module pll_reset_supervisor #(
    parameter int unsigned N_OUT        = 4,
    parameter int unsigned PLLRST_PULSE = 4,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 100,
    parameter int unsigned RELEASE_GAP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_rst,
    output logic             pll_rst,
    output logic [N_OUT-1:0] chan_rst,
    output logic             ready,
    output logic [7:0]       lost_cnt,
    output logic [7:0]       retry_cnt
);

    localparam int unsigned MAX_AB  = (PLLRST_PULSE > LOCK_STABLE) ? PLLRST_PULSE : LOCK_STABLE;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > RELEASE_GAP) ? LOCK_TIMEOUT : RELEASE_GAP;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(N_OUT + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_QUALIFY,
        S_RELEASE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic [N_OUT-1:0] chan_rst_q, chan_rst_d;
    logic             ready_q, ready_d;
    logic [7:0]       lost_q, lost_d;
    logic [7:0]       retry_q, retry_d;
    logic             locked_s;
    logic             lock_lost;

    assign locked_s = sync2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync1_d    = pll_locked;
        sync2_d    = sync1_q;
        pll_rst_d  = pll_rst_q;
        chan_rst_d = chan_rst_q;
        ready_d    = ready_q;
        lost_d     = lost_q;
        retry_d    = retry_q;
        lock_lost  = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !locked_s;

        // A lock loss is counted even when force_rst wins the same cycle.
        if (lock_lost && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end

        if (force_rst || lock_lost) begin
            state_d    = S_RESET_PLL;
            cnt_d      = '0;
            idx_d      = '0;
            pll_rst_d  = 1'b1;
            chan_rst_d = '1;
            ready_d    = 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == CW'(PLLRST_PULSE - 1)) begin
                        state_d   = S_WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        // The first locked sample already counts toward qualification.
                        if (LOCK_STABLE <= 1) begin
                            state_d    = S_RELEASE;
                            cnt_d      = '0;
                            idx_d      = IW'(1);
                            chan_rst_d = ~N_OUT'(1);
                        end else begin
                            state_d = S_QUALIFY;
                            cnt_d   = CW'(1);
                        end
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        state_d   = S_RESET_PLL;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                        if (retry_q != 8'hFF) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_QUALIFY: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                        state_d    = S_RELEASE;
                        cnt_d      = '0;
                        idx_d      = IW'(1);
                        chan_rst_d = ~N_OUT'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    // idx_q is the next channel to release; all done once it reaches N_OUT.
                    if (idx_q == IW'(N_OUT)) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                        chan_rst_d = chan_rst_q & ~(N_OUT'(1) << idx_q);
                        idx_d      = idx_q + IW'(1);
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d    = S_RESET_PLL;
                    cnt_d      = '0;
                    idx_d      = '0;
                    pll_rst_d  = 1'b1;
                    chan_rst_d = '1;
                    ready_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET_PLL;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            ready_q    <= 1'b0;
            lost_q     <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pll_rst_q  <= pll_rst_d;
            chan_rst_q <= chan_rst_d;
            ready_q    <= ready_d;
            lost_q     <= lost_d;
            retry_q    <= retry_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign chan_rst  = chan_rst_q;
    assign ready     = ready_q;
    assign lost_cnt  = lost_q;
    assign retry_cnt = retry_q;

endmodule
